// File: rtl/accel_ctrl_master_if.sv
// AXI4-Lite control-port bundle between the layer-task initiator and the
// accelerator's S_AXI_LITE_CTRL slave.
interface accel_ctrl_master_if;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/accel_ctrl_master.sv
// Programs one layer descriptor into the accelerator control registers over
// AXI4-Lite, waits for ap_done, then clears the command register.
//   state     | meaning
//   IDLE      | ready for a descriptor
//   WR/WR_RESP| descriptor write (0x04,0x08,0x0C,0x00) and its response
//   RD/RD_RESP| read-back of 0x00
//   WAIT_DONE | wait for a fresh ap_done rise or timeout
//   CLR/..RESP| write 0 to 0x00 and its response
//   FINISH    | done_pulse, back to IDLE
module accel_ctrl_master #(
    parameter bit          READBACK_EN  = 1'b1,
    parameter int unsigned DONE_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [127:0] cmd_data,
    input  logic         ap_done,
    output logic         done_pulse,
    output logic         busy,
    output logic         err_resp,
    output logic         err_readback,
    output logic         err_timeout,
    input  logic         err_clear,
    accel_ctrl_master_if.master axi
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR        = 4'd1;
    localparam logic [3:0] S_WR_RESP   = 4'd2;
    localparam logic [3:0] S_RD        = 4'd3;
    localparam logic [3:0] S_RD_RESP   = 4'd4;
    localparam logic [3:0] S_WAIT_DONE = 4'd5;
    localparam logic [3:0] S_CLR       = 4'd6;
    localparam logic [3:0] S_CLR_RESP  = 4'd7;
    localparam logic [3:0] S_FINISH    = 4'd8;

    logic [3:0]   state;
    logic [1:0]   idx;
    logic [127:0] desc;
    logic         armed;
    logic [31:0]  tmo_cnt;

    // reg_0 goes last so the start bits see the other parameters already set
    function automatic logic [4:0] wr_addr(input logic [1:0] i);
        case (i)
            2'd0:    return 5'h04;
            2'd1:    return 5'h08;
            2'd2:    return 5'h0C;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [31:0] wr_data(input logic [1:0] i, input logic [127:0] d);
        case (i)
            2'd0:    return d[63:32];
            2'd1:    return d[95:64];
            2'd2:    return d[127:96];
            default: return d[31:0];
        endcase
    endfunction

    assign axi.awprot = 3'b000;
    assign axi.arprot = 3'b000;
    assign axi.wstrb  = 4'hF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= 2'd0;
            desc         <= '0;
            armed        <= 1'b0;
            tmo_cnt      <= '0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done_pulse   <= 1'b0;
            err_resp     <= 1'b0;
            err_readback <= 1'b0;
            err_timeout  <= 1'b0;
            axi.awaddr   <= '0;
            axi.awvalid  <= 1'b0;
            axi.wdata    <= '0;
            axi.wvalid   <= 1'b0;
            axi.bready   <= 1'b0;
            axi.araddr   <= '0;
            axi.arvalid  <= 1'b0;
            axi.rready   <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            // later assignments below override the clear, so a new error wins
            if (err_clear) begin
                err_resp     <= 1'b0;
                err_readback <= 1'b0;
                err_timeout  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        desc        <= cmd_data;
                        idx         <= 2'd0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        axi.awaddr  <= wr_addr(2'd0);
                        axi.wdata   <= wr_data(2'd0, cmd_data);
                        axi.awvalid <= 1'b1;
                        axi.wvalid  <= 1'b1;
                        state       <= S_WR;
                    end
                end
                S_WR, S_CLR: begin
                    if (axi.awvalid && axi.awready) axi.awvalid <= 1'b0;
                    if (axi.wvalid && axi.wready) axi.wvalid <= 1'b0;
                    if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
                        axi.bready <= 1'b1;
                        state      <= (state == S_WR) ? S_WR_RESP : S_CLR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (axi.bvalid) begin
                        axi.bready <= 1'b0;
                        if (axi.bresp != 2'b00) err_resp <= 1'b1;
                        if (idx != 2'd3) begin
                            idx         <= idx + 2'd1;
                            axi.awaddr  <= wr_addr(idx + 2'd1);
                            axi.wdata   <= wr_data(idx + 2'd1, desc);
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                            state       <= S_WR;
                        end else if (READBACK_EN) begin
                            axi.araddr  <= 5'h00;
                            axi.arvalid <= 1'b1;
                            state       <= S_RD;
                        end else begin
                            armed   <= 1'b0;
                            tmo_cnt <= DONE_TIMEOUT;
                            state   <= S_WAIT_DONE;
                        end
                    end
                end
                S_RD: begin
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (axi.rvalid) begin
                        axi.rready <= 1'b0;
                        if (axi.rdata != desc[31:0]) err_readback <= 1'b1;
                        if (axi.rresp != 2'b00) err_resp <= 1'b1;
                        armed   <= 1'b0;
                        tmo_cnt <= DONE_TIMEOUT;
                        state   <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // a level still high from the previous task must fall first
                    if (!ap_done) armed <= 1'b1;
                    if ((armed && ap_done) || (DONE_TIMEOUT != 0 && tmo_cnt == 32'd1)) begin
                        if (!(armed && ap_done)) err_timeout <= 1'b1;
                        axi.awaddr  <= 5'h00;
                        axi.wdata   <= 32'h0;
                        axi.awvalid <= 1'b1;
                        axi.wvalid  <= 1'b1;
                        state       <= S_CLR;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
                    end
                end
                S_CLR_RESP: begin
                    if (axi.bvalid) begin
                        axi.bready <= 1'b0;
                        if (axi.bresp != 2'b00) err_resp <= 1'b1;
                        done_pulse <= 1'b1;
                        state      <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_ctrl_master.sv
// Bench for accel_ctrl_master: behavioural AXI-Lite slave, ap_done script and
// a task-level reference model for write order, completion and error flags.
module tb_accel_ctrl_master;
    localparam int TMO = 100;

    logic         clk = 1'b0;
    logic         rst, cmd_valid, err_clear, ap_done;
    logic [127:0] cmd_data;
    logic         cmd_ready, done_pulse, busy, err_resp, err_readback, err_timeout;

    accel_ctrl_master_if axi ();

    accel_ctrl_master #(.READBACK_EN(1'b1), .DONE_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .ap_done(ap_done), .done_pulse(done_pulse),
        .busy(busy), .err_resp(err_resp), .err_readback(err_readback),
        .err_timeout(err_timeout), .err_clear(err_clear), .axi(axi)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // slave policy
    int          aw_dly = 0, w_dly = 0;
    logic [4:0]  err_addr = 5'h1F;
    bit          rd_zero = 0;
    logic [15:0] ap_seq = '0;
    int          ap_len = 0;
    bit          ap_tail = 0;

    // slave state and logs
    bit          aw_got = 0, w_got = 0, ar_got = 0, in_wait = 0, r0_seen = 0;
    int          aw_cnt = 0, w_cnt = 0, wait_cnt = 0, rec_wait = -1;
    int          rd_cnt = 0, dp_cnt = 0, stab_err = 0, prot_err = 0, cyc = 0, r0_cyc = 0;
    logic [4:0]  cur_awaddr = '0, aw_first = '0;
    logic [31:0] cur_wdata = '0, w_first = '0, mem0 = '0;
    logic [4:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          awh_q[$], wh_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // cycle index of completion/timeout exit inside WAIT_DONE
    function automatic int exp_wait(input logic [15:0] seq, input int len, input bit tail,
                                    output bit tmo);
        bit armed = 0;
        bit v;
        tmo = 0;
        for (int c = 1; c <= TMO; c++) begin
            v = (c <= len) ? seq[c-1] : tail;
            if (armed && v) return c;
            if (c == TMO) begin
                tmo = 1;
                return c;
            end
            if (!v) armed = 1;
        end
        return 0;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                aw_got = 0; w_got = 0; ar_got = 0; in_wait = 0; aw_cnt = 0; w_cnt = 0;
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
                axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00;
            end else begin
                if (done_pulse) dp_cnt++;
                if (axi.awvalid && axi.awaddr == 5'h00 && !r0_seen) begin
                    r0_seen = 1;
                    r0_cyc  = cyc;
                end
                if (in_wait) begin
                    if (axi.awvalid) begin
                        rec_wait = wait_cnt;
                        in_wait  = 0;
                    end else begin
                        ap_done = (wait_cnt < ap_len) ? ap_seq[wait_cnt] : ap_tail;
                        wait_cnt++;
                    end
                end
                axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_dly);
                axi.wready  = axi.wvalid && !w_got && (w_cnt >= w_dly);
                axi.bvalid  = aw_got && w_got;
                axi.bresp   = (aw_got && cur_awaddr == err_addr) ? 2'b10 : 2'b00;
                axi.arready = axi.arvalid && !ar_got;
                axi.rvalid  = ar_got;
                axi.rdata   = rd_zero ? 32'h0 : mem0;
                axi.rresp   = 2'b00;
                if (axi.awvalid && axi.awprot != 3'b000) prot_err++;
                if (axi.wvalid && axi.wstrb != 4'hF) prot_err++;
                if (axi.arvalid && (axi.araddr != 5'h00 || axi.arprot != 3'b000)) prot_err++;
                if (axi.awvalid) begin
                    if (aw_cnt == 0) aw_first = axi.awaddr;
                    else if (axi.awaddr !== aw_first) stab_err++;
                    if (axi.awready) begin
                        aw_got = 1; cur_awaddr = axi.awaddr; awh_q.push_back(aw_cnt + 1); aw_cnt = 0;
                    end else aw_cnt++;
                end
                if (axi.wvalid) begin
                    if (w_cnt == 0) w_first = axi.wdata;
                    else if (axi.wdata !== w_first) stab_err++;
                    if (axi.wready) begin
                        w_got = 1; cur_wdata = axi.wdata; wh_q.push_back(w_cnt + 1); w_cnt = 0;
                    end else w_cnt++;
                end
                if (axi.bvalid && axi.bready) begin
                    wa_q.push_back(cur_awaddr);
                    wd_q.push_back(cur_wdata);
                    if (cur_awaddr == 5'h00) mem0 = cur_wdata;
                    aw_got = 0; w_got = 0;
                end
                if (axi.arvalid && axi.arready) ar_got = 1;
                if (axi.rvalid && axi.rready) begin
                    ar_got = 0; rd_cnt++; in_wait = 1; wait_cnt = 0;
                end
            end
        end
    end

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); awh_q.delete(); wh_q.delete();
        dp_cnt = 0; stab_err = 0; prot_err = 0; rd_cnt = 0; rec_wait = -1; r0_seen = 0;
    endtask

    task automatic run_task(input string nm, input logic [127:0] d, input int awd, input int wd,
                            input logic [4:0] ea, input bit rz, input logic [15:0] seq,
                            input int len, input bit tail, input bit idle, input bit chk_lat);
        logic [4:0]  exp_a[5];
        logic [31:0] exp_d[5];
        bit          tmo;
        int          k, n, acc_cyc;
        aw_dly = awd; w_dly = wd; err_addr = ea; rd_zero = rz;
        ap_seq = seq; ap_len = len; ap_tail = tail; ap_done = idle;
        step();
        err_clear = 1;
        step();
        err_clear = 0;
        chk({nm, "_flags_clr"}, {err_resp, err_readback, err_timeout}, 3'b000);
        clear_logs();
        chk({nm, "_rdy_idle"}, cmd_ready, 1);
        cmd_data  = d;
        cmd_valid = 1;
        acc_cyc   = cyc;
        step();
        cmd_valid = 0;
        chk({nm, "_rdy_low"}, cmd_ready, 0);
        chk({nm, "_busy"}, busy, 1);
        n = 0;
        while (!done_pulse && n < 3000) begin
            step();
            n++;
        end
        chk({nm, "_done_seen"}, done_pulse, 1);
        step();
        chk({nm, "_pulse_1cyc"}, done_pulse, 0);
        chk({nm, "_rdy_after"}, cmd_ready, 1);
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_n_pulses"}, dp_cnt, 1);

        exp_a = '{5'h04, 5'h08, 5'h0C, 5'h00, 5'h00};
        exp_d = '{d[63:32], d[95:64], d[127:96], d[31:0], 32'h0};
        k = exp_wait(seq, len, tail, tmo);
        chk({nm, "_n_writes"}, wa_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < wa_q.size()) begin
                chk($sformatf("%s_waddr%0d", nm, i), wa_q[i], exp_a[i]);
                chk($sformatf("%s_wdata%0d", nm, i), wd_q[i], exp_d[i]);
            end
        end
        foreach (awh_q[i]) chk($sformatf("%s_awhold%0d", nm, i), awh_q[i], awd + 1);
        foreach (wh_q[i]) chk($sformatf("%s_whold%0d", nm, i), wh_q[i], wd + 1);
        chk({nm, "_n_reads"}, rd_cnt, 1);
        chk({nm, "_wait_cyc"}, rec_wait, k);
        chk({nm, "_err_resp"}, err_resp, (ea != 5'h1F));
        chk({nm, "_err_rb"}, err_readback, (rz && d[31:0] != 32'h0));
        chk({nm, "_err_tmo"}, err_timeout, tmo);
        chk({nm, "_stable"}, stab_err, 0);
        chk({nm, "_prot"}, prot_err, 0);
        if (chk_lat) chk({nm, "_lat_reg0"}, r0_cyc - acc_cyc, 7);
    endtask

    initial begin
        logic [127:0] d;
        logic [4:0]   ea_tab[4];
        logic [15:0]  rs;
        int           n;
        ea_tab = '{5'h04, 5'h08, 5'h0C, 5'h1F};
        rst = 0; cmd_valid = 0; err_clear = 0; ap_done = 0; cmd_data = '0;
        #1 rst = 1;
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'b0);
        chk("rst_flags", {err_resp, err_readback, err_timeout}, 3'b000);
        chk("rst_addr_data", {axi.awaddr, axi.wdata, axi.araddr}, '0);
        step();
        step();
        rst = 0;

        d = {32'h0003_0010, 32'h0012_3456, 32'h0007_8000, 32'h1400_0211};
        run_task("zw", d, 0, 0, 5'h1F, 0, 16'h0000, 5, 1, 0, 1);
        run_task("awdly", d, 3, 0, 5'h1F, 0, 16'h0000, 2, 1, 0, 0);
        run_task("stale", d, 0, 0, 5'h1F, 0, 16'b011, 3, 1, 1, 0);
        run_task("tmo", d, 0, 0, 5'h1F, 0, 16'h0000, 0, 0, 0, 0);
        step();
        err_clear = 1;
        step();
        err_clear = 0;
        chk("tmo_cleared", err_timeout, 0);
        run_task("errs", d, 1, 2, 5'h08, 1, 16'h0000, 1, 1, 0, 0);

        // reset while awvalid waits on awready
        aw_dly = 50; w_dly = 0; err_addr = 5'h1F; rd_zero = 0;
        clear_logs();
        step();
        cmd_data = {$urandom, $urandom, $urandom, $urandom};
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        step();
        step();
        chk("mid_awvalid_pre", axi.awvalid, 1);
        #1 rst = 1;
        #1;
        chk("mid_awvalid_rst", axi.awvalid, 0);
        chk("mid_rdy_rst", cmd_ready, 1);
        chk("mid_busy_rst", busy, 0);
        step();
        step();
        rst = 0;
        step();
        chk("mid_no_pulse", dp_cnt, 0);
        chk("mid_no_done", done_pulse, 0);
        run_task("after_rst", d, 0, 0, 5'h1F, 0, 16'h0002, 3, 1, 1, 1);

        for (int t = 0; t < 6; t++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            rs = 16'($urandom);
            n  = $urandom_range(0, 6);
            run_task($sformatf("rnd%0d", t), d, $urandom_range(0, 3), $urandom_range(0, 3),
                     ea_tab[$urandom_range(0, 3)], ($urandom_range(0, 2) == 0), rs, n,
                     ($urandom_range(0, 5) != 0), $urandom_range(0, 1), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/accel_ctrl_master.md
# accel_ctrl_master

AXI-Lite initiator that programs one layer task into the convolution accelerator's four control registers and waits for the accelerator to report completion. It accepts 128-bit layer descriptors from the on-chip task scheduler over a valid/ready port, drives the write (and optional read-back) channels of the accelerator's S_AXI_LITE_CTRL port, monitors ap_done, then clears the command register so the next task starts from a clean state.

## Interface
- READBACK_EN, 1, 1 = read back register 0x00 after writing it and compare against the written value
- DONE_TIMEOUT, 0, cycles allowed in WAIT_DONE before abort; 0 = wait forever (counter width 32)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  block idle, descriptor accepted when cmd_valid & cmd_ready
- cmd_data  in  128  [31:0]=reg_0, [63:32]=reg_1, [95:64]=reg_2, [127:96]=reg_3
- ap_done  in  1  accelerator completion
- done_pulse  out  1  one-cycle pulse, task finished (with or without error)
- busy  out  1  high in every state except IDLE
- err_resp  out  1  sticky, any BRESP/RRESP != 2'b00
- err_readback  out  1  sticky, read-back mismatch
- err_timeout  out  1  sticky, DONE_TIMEOUT expired
- err_clear  in  1  clears all three sticky flags (a same-cycle new error wins)
- M_AXI_awaddr out 5, awprot out 3, awvalid out 1, awready in 1, wdata out 32, wstrb out 4, wvalid out 1, wready in 1, bresp in 2, bvalid in 1, bready out 1, araddr out 5, arprot out 3, arvalid out 1, arready in 1, rdata in 32, rresp in 2, rvalid in 1, rready out 1: AXI4-Lite master

## Operation
- States: IDLE, WR, WR_RESP, RD, RD_RESP, WAIT_DONE, CLR, CLR_RESP, FINISH.
- IDLE: cmd_ready=1; on accept, latch cmd_data, write index=0, go WR.
- Write order by index: 0→addr 0x04 (reg_1), 1→0x08 (reg_2), 2→0x0C (reg_3), 3→0x00 (reg_0). reg_0 last so conv_start/recv/send bits see consistent parameters.
- WR: awvalid and wvalid asserted together; each drops independently on its own handshake; when both done → WR_RESP. wstrb=4'hF, awprot=arprot=3'b000.
- WR_RESP: bready=1; on bvalid: bresp≠0 sets err_resp (sequence continues); index<3 → index+1, WR; index==3 → RD if READBACK_EN else WAIT_DONE.
- RD: arvalid, araddr=0x00 until arready → RD_RESP. RD_RESP: rready=1; on rvalid compare rdata with latched reg_0, mismatch sets err_readback; rresp≠0 sets err_resp → WAIT_DONE.
- WAIT_DONE: internal "armed" flag clears on entry, sets when ap_done sampled low; completion = ap_done high while armed (stale high from previous task ignored). Timeout counter counts cycles in state; reaching DONE_TIMEOUT (≠0) sets err_timeout → CLR.
- CLR: single write of 32'h0 to 0x00 (same AW/W rules) → CLR_RESP; bvalid → FINISH (bresp≠0 sets err_resp).
- FINISH: done_pulse=1 for one cycle → IDLE.
- Error never aborts the bus sequence; every issued AW/AR gets its response consumed.

## Timing
- Reset (async): state IDLE, all valid/ready outputs 0 except cmd_ready=1, busy=0, done_pulse=0, error flags 0, address/data outputs 0.
- All outputs registered; no combinational path from AXI inputs to AXI outputs.
- Minimum write transaction with awready=wready=bvalid=1: 2 cycles (WR, WR_RESP). Accept → reg_0 awvalid: 7 cycles with zero-wait slave.
- awvalid/wvalid/arvalid, once high, held with stable payload until handshake (AXI rule).
- cmd_ready low from cycle after accept through FINISH; earliest next accept is cycle after done_pulse.
- ap_done high exactly in first WAIT_DONE cycle (not armed) is ignored.
- Reset mid-transaction: immediate return to IDLE, valids drop; no partial completion signalled.

## Test plan
- Zero-wait slave, descriptor {reg_3=0x0003_0010, reg_2=0x0012_3456, reg_1=0x0007_8000, reg_0=0x1400_0211}: writes appear at 0x04,0x08,0x0C,0x00 with those data, read-back matches, ap_done low 5 cycles then high → write 0 to 0x00, one done_pulse, no errors.
- Slave delays awready 3 cycles and wready 0 cycles: wvalid drops after 1 cycle, awvalid held stable 4 cycles, single bready handshake, correct order preserved.
- ap_done held high from before accept until 2 cycles into WAIT_DONE, low 1 cycle, high again → completion only on second rise.
- DONE_TIMEOUT=100, ap_done stuck low: err_timeout set after 100 WAIT_DONE cycles, clear write issued, done_pulse; err_clear then drops flag.
- bresp=2'b10 on reg_2 write and rdata=0x0 on read-back: err_resp and err_readback set, remaining writes still issued.
- Assert rst while awvalid high awaiting awready: awvalid 0 asynchronously, cmd_ready=1, no done_pulse; next descriptor runs normally.
